// File: rtl/peripheral_spram_req_ctrl_if.sv
// Bundle of the request, response and RAM-port signals around peripheral_spram_req_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface peripheral_spram_req_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    input  rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_addr, ram_din, ram_cen, ram_wen
  );

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    output rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_addr, ram_din, ram_cen, ram_wen
  );
endinterface

// File: rtl/peripheral_spram_req_ctrl.sv
// Valid/ready front end for a single-port RAM with 1-cycle read latency.
// Read results land in a small response FIFO; out-of-range accesses never reach the RAM.
module peripheral_spram_req_ctrl #(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter int MEM_SIZE  = 256,
  parameter int RSP_DEPTH = 2
) (
  input  logic                      ram_clk,
  input  logic                      ram_rst,
  peripheral_spram_req_ctrl_if.slave bus
);
  localparam int WORDS = MEM_SIZE / 2;
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int OW    = CW + 1;

  logic [DW-1:0] data_mem [RSP_DEPTH];
  logic          err_mem  [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pend_reg;
  logic          err_reg;

  logic          acc;
  logic          inr;
  logic          rd_fire;
  logic          wr_fire;
  logic          push;
  logic          pop;
  logic          valid_int;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_after_pop;
  logic [DW-1:0] push_data;
  logic [1:0]    wen_lane;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign inr = (32'(bus.req_addr) < 32'(WORDS));

  // Ready already accounts for a same-cycle pop, so a full FIFO being drained keeps the stream moving.
  assign valid_int     = !ram_rst && (count_reg != '0);
  assign pop           = valid_int && bus.rsp_ready;
  assign occ           = OW'(count_reg) + OW'(pend_reg);
  assign occ_after_pop = occ - OW'(pop);
  assign bus.req_ready = !ram_rst && (occ_after_pop < OW'(RSP_DEPTH));

  assign acc     = bus.req_valid && bus.req_ready;
  assign rd_fire = acc && !bus.req_we && inr;
  assign wr_fire = acc && bus.req_we && inr && (bus.req_be != 2'b00);

  assign bus.ram_addr = bus.req_addr;
  assign bus.ram_din  = bus.req_wdata;
  assign bus.ram_cen  = !(rd_fire || wr_fire);

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign wen_lane[gi] = !(wr_fire && bus.req_be[gi]);
  end
  assign bus.ram_wen = wen_lane;

  // An out-of-range read still occupies a response slot, carrying zero data and the error flag.
  assign push      = pend_reg;
  assign push_data = err_reg ? '0 : bus.ram_dout;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      pend_reg   <= 1'b0;
      err_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pend_reg <= acc && !bus.req_we;
      err_reg  <= !inr;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge ram_clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= push_data;
      err_mem[wr_ptr_reg]  <= err_reg;
    end
  end

  // Head outputs are forced to zero when empty so stale entries never show after a flush.
  assign bus.rsp_valid = valid_int;
  assign bus.rsp_rdata = valid_int ? data_mem[rd_ptr_reg] : '0;
  assign bus.rsp_err   = valid_int ? err_mem[rd_ptr_reg] : 1'b0;
endmodule

// File: tb/tb_peripheral_spram_req_ctrl.sv
// Directed bench for peripheral_spram_req_ctrl with a behavioural RAM and an in-order response scoreboard.
module tb_peripheral_spram_req_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;

  logic ram_clk;
  logic ram_rst;

  peripheral_spram_req_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  peripheral_spram_req_ctrl #(
    .AW(AW), .DW(DW), .MEM_SIZE(256), .RSP_DEPTH(2)
  ) dut (
    .ram_clk(ram_clk),
    .ram_rst(ram_rst),
    .bus(bus)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  // Behavioural RAM: byte-lane writes, registered read data.
  logic [15:0] ram_mem [256];
  always @(posedge ram_clk) begin
    if (!bus.ram_cen) begin
      if (bus.ram_wen == 2'b11) begin
        bus.ram_dout <= ram_mem[bus.ram_addr];
      end else begin
        if (!bus.ram_wen[0]) ram_mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
        if (!bus.ram_wen[1]) ram_mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
      end
    end
  end

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] ref_mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        chk_lat  = 1'b0;
  logic        last_acc;
  logic        last_ready;
  logic        last_rsp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: settle, observe this cycle's handshakes, then advance one cycle.
  task automatic tick();
    logic       acc;
    logic       inr;
    logic       fire;
    logic [1:0] exp_wen;
    sb_t        e;
    #2;
    acc     = bus.req_valid && bus.req_ready;
    inr     = (bus.req_addr < 8'd128);
    fire    = acc && inr && (!bus.req_we || (bus.req_be != 2'b00));
    exp_wen = (fire && bus.req_we) ? ~bus.req_be : 2'b11;
    chk("ram_cen", 32'(bus.ram_cen), 32'(!fire));
    chk("ram_wen", 32'(bus.ram_wen), 32'(exp_wen));
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        if (chk_lat) chk("rsp_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
    if (ram_rst) sb.delete();
    if (acc) begin
      if (bus.req_we) begin
        if (fire) begin
          if (bus.req_be[0]) ref_mem[bus.req_addr][7:0]  = bus.req_wdata[7:0];
          if (bus.req_be[1]) ref_mem[bus.req_addr][15:8] = bus.req_wdata[15:8];
        end
      end else begin
        e.data = inr ? ref_mem[bus.req_addr] : 16'h0000;
        e.err  = !inr;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
    last_acc       = acc;
    last_ready     = bus.req_ready;
    last_rsp_valid = bus.rsp_valid;
    $display("cyc %0d: rst=%0b req v/r=%0b/%0b we=%0b addr=%0d be=%b | rsp v/r=%0b/%0b data=%h err=%0b | cen=%0b wen=%b",
             cyc, ram_rst, bus.req_valid, bus.req_ready, bus.req_we, bus.req_addr, bus.req_be,
             bus.rsp_valid, bus.rsp_ready, bus.rsp_rdata, bus.rsp_err, bus.ram_cen, bus.ram_wen);
    @(negedge ram_clk);
    cyc++;
  endtask

  task automatic do_req(input logic we, input logic [1:0] be, input logic [7:0] addr,
                        input logic [15:0] wdata);
    logic got;
    got           = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = last_acc;
    end
    chk("req_accept_timeout", 32'(got), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    tick();
    tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_rsp_valid", 32'(last_rsp_valid), 32'd0);
  endtask

  initial begin
    int n_acc;
    ram_rst       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    @(negedge ram_clk);

    // Reset: a request offered during reset must not be taken or reach the RAM.
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'd5;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_ram_cen", 32'(bus.ram_cen), 32'd1);
    chk("rst_ram_wen", 32'(bus.ram_wen), 32'd3);
    bus.req_valid = 1'b0;
    ram_rst       = 1'b0;

    // 1: full write then read back, with latency of two cycles.
    chk_lat = 1'b1;
    do_req(1'b1, 2'b11, 8'd5, 16'hA55A);
    do_req(1'b0, 2'b00, 8'd5, 16'h0000);
    tick();
    chk("t1_valid_t1", 32'(last_rsp_valid), 32'd0);
    tick();
    chk("t1_valid_t2", 32'(last_rsp_valid), 32'd1);
    drain();

    // 2: low-byte write merges with the old upper byte.
    do_req(1'b1, 2'b01, 8'd5, 16'h1234);
    do_req(1'b0, 2'b00, 8'd5, 16'h0000);
    drain();

    // 3: back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) do_req(1'b1, 2'b11, 8'(i), 16'h1000 + 16'(i * 16'h0111));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = 8'(i);
      tick();
      chk("t3_req_ready", 32'(last_ready), 32'd1);
    end
    drain();
    chk_lat = 1'b0;

    // 4: consumer stalled, only two reads fit, writes are blocked too.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_addr = 8'(n_acc);
      tick();
      if (last_acc) n_acc++;
    end
    chk("t4_accepted", 32'(n_acc), 32'd2);
    chk("t4_ready_low", 32'(last_ready), 32'd0);
    chk("t4_head_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t4_head_hold", 32'(bus.rsp_rdata), 32'(ref_mem[0]));
    bus.req_we    = 1'b1;
    bus.req_be    = 2'b11;
    bus.req_wdata = 16'hDEAD;
    tick();
    chk("t4_write_blocked", 32'(last_acc), 32'd0);
    chk("t4_head_hold2", 32'(bus.rsp_rdata), 32'(ref_mem[0]));
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 2'b00, 8'd2, 16'h0000);
    do_req(1'b0, 2'b00, 8'd3, 16'h0000);
    drain();

    // 5: out-of-range read yields an error response; out-of-range write is dropped.
    do_req(1'b0, 2'b00, 8'd200, 16'h0000);
    drain();
    do_req(1'b1, 2'b11, 8'd200, 16'hBEEF);
    drain();

    // 6: reset with one entry queued and one read in flight flushes both.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 2'b00, 8'd0, 16'h0000);
    do_req(1'b0, 2'b00, 8'd1, 16'h0000);
    ram_rst = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rst_cen", 32'(bus.ram_cen), 32'd1);
    ram_rst = 1'b0;
    tick();
    chk("t6_post_valid", 32'(last_rsp_valid), 32'd0);
    tick();
    chk("t6_post_valid2", 32'(last_rsp_valid), 32'd0);
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 2'b00, 8'd5, 16'h0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
